alu_mult_seq: RTL

Multi-cycle multiply sequencer that reuses the shared combinational ALU rather than adding a hardware multiplier. It computes a 16x16 to 32-bit product by iterative shift-add, driving ALU ADD, SLL and optionally SUB.
- While idle, the pipeline's opcode and operands pass straight through to the ALU.
- While busy, the sequencer owns the ALU and stalls the pipeline.
- It sits between the decode/execute stage and the ALU instance.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_port_mux.sv | 24 ++
 rtl/alu_mult_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the multiply sequencer: ALU opcodes, default widths and FSM encoding.
// The NEG state only exists when ALU_MULT_SIGNED_EN is defined.
package alu_pkg;

  localparam int unsigned OP_W_DEF  = 16;
  localparam int unsigned ALU_W_DEF = 32;
  localparam int unsigned OPC_W     = 6;

  localparam logic [OPC_W-1:0] ALU_OP_ADD = 6'h00;
  localparam logic [OPC_W-1:0] ALU_OP_SUB = 6'h02;
  localparam logic [OPC_W-1:0] ALU_OP_SLL = 6'h05;
  localparam logic [OPC_W-1:0] ALU_OP_NOP = 6'h3F;

`ifdef ALU_MULT_SIGNED_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAdd   = 3'd1,
    StShift = 3'd2,
    StNeg   = 3'd3,
    StDone  = 3'd4
  } mult_state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAdd   = 3'd1,
    StShift = 3'd2,
    StDone  = 3'd4
  } mult_state_e;
`endif

endpackage

// File: rtl/alu_port_mux.sv
// Selects who drives the shared ALU: the pipeline when the sequencer is idle,
// the multiply sequencer while it is busy.
module alu_port_mux
  import alu_pkg::*;
#(
  parameter int unsigned ALU_W = ALU_W_DEF
) (
  input  logic             i_sel_seq,
  input  logic [OPC_W-1:0] i_pipe_opcode,
  input  logic [ALU_W-1:0] i_pipe_in1,
  input  logic [ALU_W-1:0] i_pipe_in2,
  input  logic [OPC_W-1:0] i_seq_opcode,
  input  logic [ALU_W-1:0] i_seq_in1,
  input  logic [ALU_W-1:0] i_seq_in2,
  output logic [OPC_W-1:0] o_alu_opcode,
  output logic [ALU_W-1:0] o_alu_in1,
  output logic [ALU_W-1:0] o_alu_in2
);

  assign o_alu_opcode = i_sel_seq ? i_seq_opcode : i_pipe_opcode;
  assign o_alu_in1    = i_sel_seq ? i_seq_in1    : i_pipe_in1;
  assign o_alu_in2    = i_sel_seq ? i_seq_in2    : i_pipe_in2;

endmodule

// File: rtl/alu_mult_seq.sv
// Shift-add multiply sequencer that borrows the shared ALU for ADD/SLL (and SUB for sign fix-up).
// Define ALU_MULT_SIGNED_EN to add i_signed_op and the two's-complement NEG step.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int unsigned OP_W  = OP_W_DEF,
  parameter int unsigned ALU_W = ALU_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
`ifdef ALU_MULT_SIGNED_EN
  input  logic             i_signed_op,
`endif
  input  logic [OP_W-1:0]  i_op_a,
  input  logic [OP_W-1:0]  i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [ALU_W-1:0] o_result,
  output logic             o_res_n,
  output logic             o_res_z,
  output logic             o_res_v,
  input  logic [OPC_W-1:0] i_pipe_opcode,
  input  logic [ALU_W-1:0] i_pipe_in1,
  input  logic [ALU_W-1:0] i_pipe_in2,
  output logic [OPC_W-1:0] o_alu_opcode,
  output logic [ALU_W-1:0] o_alu_in1,
  output logic [ALU_W-1:0] o_alu_in2,
  input  logic [ALU_W-1:0] i_alu_out
);

  localparam int unsigned CNT_W = $clog2(OP_W) + 1;

  mult_state_e      r_state, w_state_d;
  logic [ALU_W-1:0] r_mc, w_mc_d;
  logic [OP_W-1:0]  r_mp, w_mp_d;
  logic [ALU_W-1:0] r_acc, w_acc_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [ALU_W-1:0] r_result, w_result_d;
  logic             r_res_n, r_res_z;
  logic             w_load_res;

  logic [OPC_W-1:0] w_seq_opcode;
  logic [ALU_W-1:0] w_seq_in1, w_seq_in2;
  logic [OP_W-1:0]  w_mag_a, w_mag_b;
  logic             w_last;

`ifdef ALU_MULT_SIGNED_EN
  logic r_sgn, w_sgn_d;
  logic w_neg_a, w_neg_b;

  // Operands are reduced to magnitudes; the sign is reapplied in NEG.
  assign w_neg_a = i_signed_op & i_op_a[OP_W-1];
  assign w_neg_b = i_signed_op & i_op_b[OP_W-1];
  assign w_mag_a = w_neg_a ? (~i_op_a + OP_W'(1)) : i_op_a;
  assign w_mag_b = w_neg_b ? (~i_op_b + OP_W'(1)) : i_op_b;
`else
  assign w_mag_a = i_op_a;
  assign w_mag_b = i_op_b;
`endif

  assign w_last = (r_mp[OP_W-1:1] == '0) || (r_cnt == CNT_W'(OP_W - 1));

  always_comb begin
    w_state_d    = r_state;
    w_mc_d       = r_mc;
    w_mp_d       = r_mp;
    w_acc_d      = r_acc;
    w_cnt_d      = r_cnt;
    w_result_d   = r_result;
    w_load_res   = 1'b0;
    w_seq_opcode = ALU_OP_NOP;
    w_seq_in1    = '0;
    w_seq_in2    = '0;
`ifdef ALU_MULT_SIGNED_EN
    w_sgn_d      = r_sgn;
`endif

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_mc_d    = {{(ALU_W-OP_W){1'b0}}, w_mag_a};
          w_mp_d    = w_mag_b;
          w_acc_d   = '0;
          w_cnt_d   = '0;
`ifdef ALU_MULT_SIGNED_EN
          w_sgn_d   = w_neg_a ^ w_neg_b;
`endif
          w_state_d = StAdd;
        end else begin
          w_state_d = StIdle;
        end
      end

      StAdd: begin
        if (r_mp[0]) begin
          w_seq_opcode = ALU_OP_ADD;
          w_seq_in1    = r_acc;
          w_seq_in2    = r_mc;
          w_acc_d      = i_alu_out;
        end
        w_state_d = StShift;
      end

      StShift: begin
        w_seq_opcode = ALU_OP_SLL;
        w_seq_in1    = r_mc;
        w_seq_in2    = ALU_W'(1);
        w_mc_d       = i_alu_out;
        w_mp_d       = r_mp >> 1;
        w_cnt_d      = r_cnt + CNT_W'(1);
        if (w_last) begin
`ifdef ALU_MULT_SIGNED_EN
          if (r_sgn) begin
            w_state_d = StNeg;
          end else begin
            w_state_d  = StDone;
            w_result_d = r_acc;
            w_load_res = 1'b1;
          end
`else
          w_state_d  = StDone;
          w_result_d = r_acc;
          w_load_res = 1'b1;
`endif
        end else begin
          w_state_d = StAdd;
        end
      end

`ifdef ALU_MULT_SIGNED_EN
      StNeg: begin
        w_seq_opcode = ALU_OP_SUB;
        w_seq_in1    = '0;
        w_seq_in2    = r_acc;
        w_acc_d      = i_alu_out;
        w_result_d   = i_alu_out;
        w_load_res   = 1'b1;
        w_state_d    = StDone;
      end
`endif

      default: w_state_d = StIdle;
    endcase
  end

  // Result and flags are loaded on the edge into DONE so they are valid with the done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_mc     <= '0;
      r_mp     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_res_n  <= 1'b0;
      r_res_z  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_mc    <= w_mc_d;
      r_mp    <= w_mp_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      if (w_load_res) begin
        r_result <= w_result_d;
        r_res_n  <= w_result_d[ALU_W-1];
        r_res_z  <= (w_result_d == '0);
      end
    end
  end

`ifdef ALU_MULT_SIGNED_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sgn <= 1'b0;
    end else begin
      r_sgn <= w_sgn_d;
    end
  end
`endif

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StDone:  o_done = 1'b1;
      StIdle:  o_busy = 1'b0;
      default: o_busy = 1'b1;
    endcase
  end

  assign o_result = r_result;
  assign o_res_n  = r_res_n;
  assign o_res_z  = r_res_z;
  assign o_res_v  = 1'b0;

  alu_port_mux #(
    .ALU_W(ALU_W)
  ) u_port_mux (
    .i_sel_seq    (o_busy),
    .i_pipe_opcode(i_pipe_opcode),
    .i_pipe_in1   (i_pipe_in1),
    .i_pipe_in2   (i_pipe_in2),
    .i_seq_opcode (w_seq_opcode),
    .i_seq_in1    (w_seq_in1),
    .i_seq_in2    (w_seq_in2),
    .o_alu_opcode (o_alu_opcode),
    .o_alu_in1    (o_alu_in1),
    .o_alu_in2    (o_alu_in2)
  );

endmodule
